pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Collects per-stage stall requests, branch-mispredict redirects from EX and exception/ertn redirects from WB commit.
- Drives the stall and flush inputs of the five pipeline registers (R0=PC, R1=IF_ID, R2=ID_EX, R3=EX_MEM, R4=MEM_WB) plus the PC redirect.
- Delays a flush while an un-abortable IF or MEM bus transaction is outstanding, and counts stall cycles for perf.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_stall_enc.sv | 17 +
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and types for the pipeline sequencer
// Stage indices, flush patterns, redirect kinds and FSM state encodings.
package pipe_ctrl_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [4:0] FLUSH_BR  = 5'b00110;
  localparam logic [4:0] FLUSH_EXC = 5'b11110;

  typedef enum logic {
    KIND_BR  = 1'b0,
    KIND_EXC = 1'b1
  } kind_e;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/pipe_stall_enc.sv
// rtl/pipe_stall_enc.sv - priority encoder from stage stall requests to stall mask
// The highest requesting stage stalls itself and every younger stage; WB never stalls.
module pipe_stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] req_i,
  output logic [4:0] mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = STG_IF; i <= STG_MEM; i++) begin
      mask_o[i] = |(req_i >> i);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with redirect drain FSM
// Redirects are deferred in DRAIN while an un-abortable bus transaction is outstanding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              mem_stall_req,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              br_redirect,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_redirect,
  input  logic [ADDR_W-1:0] exc_target,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              draining,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [0:0]        state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic [4:0]        stall_mask;
  logic              br_eff;
  logic              exc_eff;
  kind_e             kind_c;
  logic [ADDR_W-1:0] tgt_c;
  logic              wait_busy;

  pipe_stall_enc u_stall_enc (
    .req_i  ({mem_stall_req, ex_stall_req, id_stall_req, if_stall_req}),
    .mask_o (stall_mask)
  );

  // An older MEM/EX stall holds the mispredicted branch in EX until it can move.
  assign br_eff  = br_redirect && !ex_stall_req && !mem_stall_req;
  assign exc_eff = exc_redirect;

  // An exception arriving during a branch drain is older, so it replaces the branch.
  always_comb begin
    kind_c = kind_q;
    tgt_c  = tgt_q;
    if (kind_q == KIND_BR && exc_redirect) begin
      kind_c = KIND_EXC;
      tgt_c  = exc_target;
    end
  end

  assign wait_busy = (kind_c == KIND_EXC) ? (if_busy || mem_busy) : if_busy;

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    tgt_d          = tgt_q;
    stall_o        = stall_mask;
    flush_o        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    if (state_q == ST_RUN) begin
      if (exc_eff) begin
        if (!if_busy && !mem_busy) begin
          flush_o        = FLUSH_EXC;
          redirect_valid = 1'b1;
          redirect_pc    = exc_target;
          stall_o        = '0;
        end else begin
          kind_d  = KIND_EXC;
          tgt_d   = exc_target;
          state_d = ST_DRAIN;
        end
      end else if (br_eff) begin
        if (!if_busy) begin
          flush_o        = FLUSH_BR;
          redirect_valid = 1'b1;
          redirect_pc    = br_target;
          stall_o        = stall_mask & 5'b11100;
        end else begin
          kind_d  = KIND_BR;
          tgt_d   = br_target;
          state_d = ST_DRAIN;
        end
      end
    end else begin
      stall_o = 5'b11111;
      kind_d  = kind_c;
      tgt_d   = tgt_c;
      if (!wait_busy) begin
        // Release looks exactly like an immediate redirect of the latched kind.
        redirect_valid = 1'b1;
        redirect_pc    = tgt_c;
        state_d        = ST_RUN;
        if (kind_c == KIND_EXC) begin
          flush_o = FLUSH_EXC;
          stall_o = '0;
        end else begin
          flush_o = FLUSH_BR;
          stall_o = stall_mask & 5'b11100;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      kind_q      <= KIND_BR;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      tgt_q   <= tgt_d;
      if (|stall_o) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (redirect_valid) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign draining  = (state_q == ST_DRAIN);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
// Expected redirects are queued at stimulus time and matched by a negedge monitor.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
  logic        if_busy, mem_busy;
  logic        br_redirect, exc_redirect;
  logic [31:0] br_target, exc_target;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        draining;
  logic [31:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  fl;
  } redir_t;

  redir_t sb[$];
  int     n_cmp;
  int     n_err;

  pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .ex_stall_req   (ex_stall_req),
    .mem_stall_req  (mem_stall_req),
    .if_busy        (if_busy),
    .mem_busy       (mem_busy),
    .br_redirect    (br_redirect),
    .br_target      (br_target),
    .exc_redirect   (exc_redirect),
    .exc_target     (exc_target),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .draining       (draining),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && redirect_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: redirect pc=%h flush=%b, none expected", redirect_pc, flush_o);
      end else begin
        redir_t e;
        e = sb.pop_front();
        if (redirect_pc !== e.pc || flush_o !== e.fl) begin
          n_err++;
          $display("FAIL sb_redirect: got pc=%h flush=%b, want pc=%h flush=%b",
                   redirect_pc, flush_o, e.pc, e.fl);
        end
      end
    end
  end

  function automatic logic [4:0] exp_mask(input logic [3:0] r);
    logic [4:0] m;
    m = 5'b00000;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) begin
        m = 5'((1 << (k + 1)) - 1);
        break;
      end
    end
    return m;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_stall_req = 0; id_stall_req = 0; ex_stall_req = 0; mem_stall_req = 0;
    if_busy = 0; mem_busy = 0; br_redirect = 0; exc_redirect = 0;
    br_target = '0; exc_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({stall_o, flush_o, redirect_valid, redirect_pc, draining} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: stall=%b flush=%b rv=%b pc=%h dr=%b, want all 0",
               stall_o, flush_o, redirect_valid, redirect_pc, draining);
    end
    n_cmp++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_cnts: stall_cnt=%0d flush_cnt=%0d, want 0 0", stall_cnt, flush_cnt);
    end
    next_cycle();
    rst = 0;
  endtask

  task automatic test_stall();
    logic [3:0] r;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      r = 4'(i);
      {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = r;
      @(negedge clk);
      n_cmp++;
      if (stall_o !== exp_mask(r) || flush_o !== 5'b0) begin
        n_err++;
        $display("FAIL stall_mask req=%b: stall=%b flush=%b, want stall=%b flush=00000",
                 r, stall_o, flush_o, exp_mask(r));
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 32'd15) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d, want 15", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_branch();
    do_reset();
    br_redirect = 1; br_target = 32'h1c000100;
    sb.push_back('{pc: 32'h1c000100, fl: 5'b00110});
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b1 || flush_o !== 5'b00110 || stall_o !== 5'b0) begin
      n_err++;
      $display("FAIL br_same_cycle: rv=%b flush=%b stall=%b, want 1 00110 00000",
               redirect_valid, flush_o, stall_o);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (flush_cnt !== 32'd1 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL br_flush_cnt: flush_cnt=%0d rv=%b, want 1 0", flush_cnt, redirect_valid);
    end
    next_cycle();
  endtask

  task automatic test_br_held();
    do_reset();
    br_redirect = 1; br_target = 32'h1c000200; mem_stall_req = 1;
    sb.push_back('{pc: 32'h1c000200, fl: 5'b00110});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (redirect_valid !== 1'b0 || stall_o !== 5'b01111) begin
        n_err++;
        $display("FAIL br_held cyc%0d: rv=%b stall=%b, want 0 01111", i, redirect_valid, stall_o);
      end
      next_cycle();
    end
    mem_stall_req = 0;
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b1) begin
      n_err++;
      $display("FAIL br_release: rv=%b, want 1", redirect_valid);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_exc_drain();
    do_reset();
    exc_redirect = 1; exc_target = 32'h1c008000; mem_busy = 1;
    sb.push_back('{pc: 32'h1c008000, fl: 5'b11110});
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b0 || draining !== 1'b0) begin
      n_err++;
      $display("FAIL exc_latch: rv=%b dr=%b, want 0 0", redirect_valid, draining);
    end
    next_cycle();
    exc_redirect = 0; exc_target = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (draining !== 1'b1 || stall_o !== 5'b11111 || redirect_valid !== 1'b0 || flush_o !== 5'b0) begin
        n_err++;
        $display("FAIL exc_drain cyc%0d: dr=%b stall=%b rv=%b flush=%b, want 1 11111 0 00000",
                 i, draining, stall_o, redirect_valid, flush_o);
      end
      next_cycle();
    end
    mem_busy = 0;
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b1 || flush_o !== 5'b11110) begin
      n_err++;
      $display("FAIL exc_fire: rv=%b flush=%b, want 1 11110", redirect_valid, flush_o);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (draining !== 1'b0 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL exc_back_run: dr=%b rv=%b, want 0 0", draining, redirect_valid);
    end
    next_cycle();
  endtask

  task automatic test_br_then_exc();
    do_reset();
    br_redirect = 1; br_target = 32'h00000100; if_busy = 1;
    sb.push_back('{pc: 32'h00008000, fl: 5'b11110});
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL brx_latch: rv=%b, want 0", redirect_valid);
    end
    next_cycle();
    br_redirect = 0; br_target = '0; exc_redirect = 1; exc_target = 32'h00008000;
    @(negedge clk);
    n_cmp++;
    if (draining !== 1'b1 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL brx_relatch: dr=%b rv=%b, want 1 0", draining, redirect_valid);
    end
    next_cycle();
    exc_redirect = 0; exc_target = '0; if_busy = 0;
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00008000 || flush_o !== 5'b11110) begin
      n_err++;
      $display("FAIL brx_fire: rv=%b pc=%h flush=%b, want 1 00008000 11110",
               redirect_valid, redirect_pc, flush_o);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (flush_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL brx_flush_cnt: got %0d, want 1", flush_cnt);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      br_redirect = 1; br_target = 32'h1c000000 + 32'(i * 16);
      sb.push_back('{pc: 32'h1c000000 + 32'(i * 16), fl: 5'b00110});
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (flush_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL b2b_flush_cnt: got %0d, want 3", flush_cnt);
    end
    next_cycle();
  endtask

  task automatic test_rst_drain();
    do_reset();
    exc_redirect = 1; exc_target = 32'h1c00beef; mem_busy = 1;
    next_cycle();
    exc_redirect = 0;
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0; mem_busy = 0; exc_target = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({stall_o, flush_o, redirect_valid, redirect_pc, draining} !== '0 || stall_cnt !== 0) begin
        n_err++;
        $display("FAIL rst_drain cyc%0d: stall=%b flush=%b rv=%b pc=%h dr=%b scnt=%0d, want all 0",
                 i, stall_o, flush_o, redirect_valid, redirect_pc, draining, stall_cnt);
      end
      next_cycle();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    rst = 1;
    test_reset();
    test_stall();
    test_branch();
    test_br_held();
    test_exc_drain();
    test_br_then_exc();
    test_back_to_back();
    test_rst_drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d redirects never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
